// File: rtl/rv32_ibus_bridge_if.sv
// Instruction-memory bus between the fetch bridge (master) and the memory (slave).
// One request is outstanding at a time; responses are qualified by mem_rvalid_in.
interface rv32_ibus_bridge_if;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_gnt_in;
    logic        mem_rvalid_in;
    logic [31:0] mem_rdata_in;
    logic        mem_err_in;

    modport master (
        output mem_req_out,
        output mem_addr_out,
        input  mem_gnt_in,
        input  mem_rvalid_in,
        input  mem_rdata_in,
        input  mem_err_in
    );

    modport slave (
        input  mem_req_out,
        input  mem_addr_out,
        output mem_gnt_in,
        output mem_rvalid_in,
        output mem_rdata_in,
        output mem_err_in
    );
endinterface

// File: rtl/rv32_ibus_bridge.sv
// Fetch-to-instruction-memory bridge with a one-entry holding register,
// one outstanding transaction, response timeout and flush handling.
module rv32_ibus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_WORD       = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce_i,
    input  logic                    flush_in,
    input  logic                    instr_read_in,
    input  logic [31:0]             instr_address_in,
    output logic [31:0]             instr_read_value_out,
    output logic                    instr_fault_out,
    output logic                    instr_ready_out,
    rv32_ibus_bridge_if.master      mem
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TAG_W = 30;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e             state_q,      state_d;
    logic               mem_req_q,    mem_req_d;
    logic [31:0]        mem_addr_q,   mem_addr_d;
    logic               hold_valid_q, hold_valid_d;
    logic [TAG_W-1:0]   hold_tag_q,   hold_tag_d;
    logic [31:0]        hold_data_q,  hold_data_d;
    logic               hold_fault_q, hold_fault_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;

    logic               aligned;
    logic               hit;
    logic               misaligned;
    logic               aligned_miss;
    logic [CNT_W-1:0]   cnt_inc;

    // Fetch-side decode against the holding register.
    assign aligned      = (instr_address_in[1:0] == 2'b00);
    assign hit          = instr_read_in && aligned && hold_valid_q &&
                          (hold_tag_q == instr_address_in[31:2]);
    assign misaligned   = instr_read_in && !aligned;
    assign aligned_miss = instr_read_in && aligned && !hit;
    assign cnt_inc      = cnt_q + CNT_W'(1);

    assign instr_ready_out      = hit || misaligned;
    assign instr_fault_out      = hit ? hold_fault_q : misaligned;
    assign instr_read_value_out = hit ? hold_data_q  : NOP_WORD;

    assign mem.mem_req_out  = mem_req_q;
    assign mem.mem_addr_out = mem_addr_q;

    // Next-state and holding-register update.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        hold_valid_d = hold_valid_q;
        hold_tag_d   = hold_tag_q;
        hold_data_d  = hold_data_q;
        hold_fault_d = hold_fault_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (aligned_miss && !flush_in) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {instr_address_in[31:2], 2'b00};
                end
            end
            S_REQ: begin
                if (mem.mem_gnt_in) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = flush_in ? S_DRAIN : S_WAIT;
                end else if (flush_in) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid_in) begin
                    state_d = S_IDLE;
                    if (!flush_in) begin
                        hold_valid_d = 1'b1;
                        hold_tag_d   = mem_addr_q[31:2];
                        hold_fault_d = mem.mem_err_in;
                        hold_data_d  = mem.mem_err_in ? NOP_WORD : mem.mem_rdata_in;
                    end
                end else if (flush_in) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (cnt_inc == TIMEOUT_VAL) begin
                    // Timed-out fetch is answered with a faulted NOP; a late response is drained.
                    hold_valid_d = 1'b1;
                    hold_tag_d   = mem_addr_q[31:2];
                    hold_fault_d = 1'b1;
                    hold_data_d  = NOP_WORD;
                    state_d      = S_DRAIN;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DRAIN: begin
                if (mem.mem_rvalid_in || (cnt_inc == TIMEOUT_VAL)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over any same-cycle fill.
        if (flush_in) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hold_valid_q <= 1'b0;
            hold_tag_q   <= '0;
            hold_data_q  <= NOP_WORD;
            hold_fault_q <= 1'b0;
            cnt_q        <= '0;
        end else if (ce_i) begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            hold_valid_q <= hold_valid_d;
            hold_tag_q   <= hold_tag_d;
            hold_data_q  <= hold_data_d;
            hold_fault_q <= hold_fault_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rv32_ibus_bridge.sv
// Directed and randomized checks of rv32_ibus_bridge against a one-entry
// cache model and a scripted memory responder.
module tb_rv32_ibus_bridge;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        flush;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] rvalue;
    logic        fault;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    // Reference model of the holding register: what fetch should see on a repeat read.
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_fault;

    logic [31:0] pool [4] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_2000, 32'h0000_3ffc};

    rv32_ibus_bridge_if bus ();

    rv32_ibus_bridge #(
        .TIMEOUT_CYCLES (TO),
        .NOP_WORD       (NOP)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .ce_i                 (ce),
        .flush_in             (flush),
        .instr_read_in        (rd),
        .instr_address_in     (addr),
        .instr_read_value_out (rvalue),
        .instr_fault_out      (fault),
        .instr_ready_out      (ready),
        .mem                  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic er, input logic ef, input logic [31:0] ev);
        chkb({tag, ".rdy"}, ready, er);
        chkb({tag, ".flt"}, fault, ef);
        chk({tag, ".val"}, rvalue, ev);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Miss at addr a: grant after g extra REQ cycles, response in the d-th WAIT cycle (d>=1).
    task automatic do_miss(input logic [31:0] a, input int unsigned g, input int unsigned d,
                           input logic [31:0] data, input logic err);
        rd   = 1'b1;
        addr = a;
        settle();
        chkb("miss.rdy0", ready, 1'b0);
        tick();
        chkb("miss.req", bus.mem_req_out, 1'b1);
        chk("miss.addr", bus.mem_addr_out, a);
        repeat (g) begin
            addr = a ^ 32'h0000_0010;
            tick();
            chkb("req.hold", bus.mem_req_out, 1'b1);
            chk("req.addr_hold", bus.mem_addr_out, a);
        end
        bus.mem_gnt_in = 1'b1;
        tick();
        bus.mem_gnt_in = 1'b0;
        chkb("gnt.req_drop", bus.mem_req_out, 1'b0);
        repeat (d - 1) tick();
        addr = a;
        settle();
        chkb("wait.rdy0", ready, 1'b0);
        bus.mem_rvalid_in = 1'b1;
        bus.mem_rdata_in  = data;
        bus.mem_err_in    = err;
        tick();
        bus.mem_rvalid_in = 1'b0;
        bus.mem_err_in    = 1'b0;
        settle();
        chk_out("fill", 1'b1, err, err ? NOP : data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        ce                = 1'b1;
        flush             = 1'b0;
        rd                = 1'b0;
        addr              = '0;
        bus.mem_gnt_in    = 1'b0;
        bus.mem_rvalid_in = 1'b0;
        bus.mem_rdata_in  = '0;
        bus.mem_err_in    = 1'b0;
        m_valid           = 1'b0;
        m_addr            = '0;
        m_data            = NOP;
        m_fault           = 1'b0;

        // Reset state
        tick();
        chk_out("reset", 1'b0, 1'b0, NOP);
        chkb("reset.req", bus.mem_req_out, 1'b0);
        chk("reset.addr", bus.mem_addr_out, 32'h0);
        tick();
        reset = 1'b0;

        // Miss then hit at minimum latency
        do_miss(32'h0000_0100, 0, 1, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk_out("hit", 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        chkb("hit.noreq", bus.mem_req_out, 1'b0);

        // Misaligned request leaves the holding register alone
        addr = 32'h0000_0102;
        settle();
        chk_out("misal", 1'b1, 1'b1, NOP);
        tick();
        chkb("misal.noreq", bus.mem_req_out, 1'b0);
        addr = 32'h0000_0100;
        settle();
        chk_out("misal.keep", 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();

        // Bus error response
        do_miss(32'h0000_0200, 0, 1, 32'hCAFE_F00D, 1'b1);
        tick();

        // Timeout, then a late response dropped in DRAIN
        addr = 32'h0000_0300;
        settle();
        chkb("to.rdy0", ready, 1'b0);
        tick();
        chkb("to.req", bus.mem_req_out, 1'b1);
        bus.mem_gnt_in = 1'b1;
        tick();
        bus.mem_gnt_in = 1'b0;
        tick();
        tick();
        tick();
        chkb("to.wait4", ready, 1'b0);
        tick();
        chk_out("to.fault", 1'b1, 1'b1, NOP);
        bus.mem_rvalid_in = 1'b1;
        bus.mem_rdata_in  = 32'h0BAD_0BAD;
        tick();
        bus.mem_rvalid_in = 1'b0;
        settle();
        chk_out("to.late_drop", 1'b1, 1'b1, NOP);
        tick();
        do_miss(32'h0000_0400, 0, 1, 32'h4444_0000, 1'b0);
        tick();

        // Flush in WAIT, response two cycles later
        addr = 32'h0000_0500;
        settle();
        chkb("fl.rdy0", ready, 1'b0);
        tick();
        chkb("fl.req", bus.mem_req_out, 1'b1);
        bus.mem_gnt_in = 1'b1;
        tick();
        bus.mem_gnt_in = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        addr  = 32'h0000_0400;
        settle();
        chkb("fl.hold_clr", ready, 1'b0);
        tick();
        bus.mem_rvalid_in = 1'b1;
        bus.mem_rdata_in  = 32'h5555_5555;
        addr              = 32'h0000_0500;
        tick();
        bus.mem_rvalid_in = 1'b0;
        settle();
        chkb("fl.discard", ready, 1'b0);
        tick();
        chkb("fl.rereq", bus.mem_req_out, 1'b1);
        chk("fl.rereq_addr", bus.mem_addr_out, 32'h0000_0500);
        bus.mem_gnt_in = 1'b1;
        tick();
        bus.mem_gnt_in    = 1'b0;
        bus.mem_rvalid_in = 1'b1;
        bus.mem_rdata_in  = 32'h5050_5050;
        tick();
        bus.mem_rvalid_in = 1'b0;
        settle();
        chk_out("fl.refill", 1'b1, 1'b0, 32'h5050_5050);
        tick();

        // Flush coinciding with rvalid: no fill
        addr = 32'h0000_0600;
        tick();
        chkb("flrv.req", bus.mem_req_out, 1'b1);
        bus.mem_gnt_in = 1'b1;
        tick();
        bus.mem_gnt_in    = 1'b0;
        bus.mem_rvalid_in = 1'b1;
        bus.mem_rdata_in  = 32'h6666_6666;
        flush             = 1'b1;
        tick();
        bus.mem_rvalid_in = 1'b0;
        flush             = 1'b0;
        settle();
        chkb("flrv.nofill", ready, 1'b0);
        tick();
        chkb("flrv.rereq", bus.mem_req_out, 1'b1);
        bus.mem_gnt_in = 1'b1;
        tick();
        bus.mem_gnt_in = 1'b0;

        // Reset mid-WAIT, then a stray response
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst.mid", 1'b0, 1'b0, NOP);
        chkb("rst.req", bus.mem_req_out, 1'b0);
        chk("rst.addr", bus.mem_addr_out, 32'h0);
        tick();
        reset             = 1'b0;
        rd                = 1'b0;
        bus.mem_rvalid_in = 1'b1;
        bus.mem_rdata_in  = 32'h7777_7777;
        tick();
        bus.mem_rvalid_in = 1'b0;
        chkb("stray.noreq", bus.mem_req_out, 1'b0);
        rd   = 1'b1;
        addr = 32'h0000_0600;
        settle();
        chk_out("stray.nofill", 1'b0, 1'b0, NOP);
        tick();
        chkb("stray.req", bus.mem_req_out, 1'b1);
        flush = 1'b1;
        rd    = 1'b0;
        tick();
        flush = 1'b0;
        chkb("flreq.drop", bus.mem_req_out, 1'b0);
        tick();
        chkb("noread.noreq", bus.mem_req_out, 1'b0);

        // Clock enable low freezes the request
        ce   = 1'b0;
        rd   = 1'b1;
        addr = 32'h0000_0700;
        tick();
        chkb("ce.hold1", bus.mem_req_out, 1'b0);
        tick();
        chkb("ce.hold2", bus.mem_req_out, 1'b0);
        ce = 1'b1;
        tick();
        chkb("ce.req", bus.mem_req_out, 1'b1);
        chk("ce.addr", bus.mem_addr_out, 32'h0000_0700);
        bus.mem_gnt_in = 1'b1;
        tick();
        bus.mem_gnt_in    = 1'b0;
        bus.mem_rvalid_in = 1'b1;
        bus.mem_rdata_in  = 32'h7070_7070;
        tick();
        bus.mem_rvalid_in = 1'b0;
        settle();
        chk_out("ce.fill", 1'b1, 1'b0, 32'h7070_7070);

        // Randomized fetch stream against the one-entry model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [31:0] data;
            logic        err;
            int unsigned k;
            k = $urandom_range(0, 7);
            a = pool[$urandom_range(0, 3)];
            if (k == 7) begin
                rd = 1'b0;
                tick();
                chkb("rnd.idle_noreq", bus.mem_req_out, 1'b0);
            end else if (k == 0) begin
                rd   = 1'b1;
                addr = a | 32'($urandom_range(1, 3));
                settle();
                chk_out("rnd.misal", 1'b1, 1'b1, NOP);
                tick();
                chkb("rnd.misal_noreq", bus.mem_req_out, 1'b0);
            end else if (m_valid && (m_addr == a)) begin
                rd   = 1'b1;
                addr = a;
                settle();
                chk_out("rnd.hit", 1'b1, m_fault, m_data);
                tick();
                chkb("rnd.hit_noreq", bus.mem_req_out, 1'b0);
            end else begin
                data = $urandom;
                err  = ($urandom_range(0, 4) == 0);
                do_miss(a, $urandom_range(0, 3), $urandom_range(1, 3), data, err);
                m_valid = 1'b1;
                m_addr  = a;
                m_data  = err ? NOP : data;
                m_fault = err;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_ibus_bridge.md
RV32_IBUS_BRIDGE -- requirements
Module: rv32_ibus_bridge

Sits between the fetch stage's instruction port and a variable-latency instruction memory. Has a one-entry holding register. Only one bus transaction is outstanding at a time.

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles the block waits for a response before raising a fault; range 1..255, held in an 8-bit counter.
REQ-002 Parameter NOP_WORD, default 32'h00000013: value driven on instr_read_value_out when no valid word is held.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ce_i  in  1  clock enable; when low, all registered state holds.
REQ-006 flush_in  in  1  invalidates the holding register and discards any in-flight response.
REQ-007 instr_read_in  in  1  fetch requests the word at instr_address_in.
REQ-008 instr_address_in  in  32  fetch PC.
REQ-009 instr_read_value_out  out  32  instruction word returned to fetch.
REQ-010 instr_fault_out  out  1  the returned word is faulted.
REQ-011 instr_ready_out  out  1  instr_read_value_out/instr_fault_out are valid for the current instr_address_in; fetch and pcgen stall while this is low.
REQ-012 mem_req_out  out  1  bus request.
REQ-013 mem_addr_out  out  32  bus word address; bits [1:0] are always 0.
REQ-014 mem_gnt_in  in  1  request accepted in a cycle where mem_req_out=1.
REQ-015 mem_rvalid_in  in  1  response valid; earliest one cycle after the grant.
REQ-016 mem_rdata_in  in  32  response data.
REQ-017 mem_err_in  in  1  response error; qualified by mem_rvalid_in.

Function
REQ-018 Holding register fields: hold_valid, hold_tag[31:2], hold_data[31:0], hold_fault.
REQ-019 Hit condition: instr_read_in && hold_valid && hold_tag==instr_address_in[31:2] && instr_address_in[1:0]==0.
REQ-020 On a hit, the combinational outputs are instr_ready_out=1, instr_read_value_out=hold_data and instr_fault_out=hold_fault.
REQ-021 Misaligned request (instr_read_in && instr_address_in[1:0]!=0):
- combinational response: instr_ready_out=1, instr_fault_out=1, instr_read_value_out=NOP_WORD;
- no bus request is issued and the holding register is unchanged.
REQ-022 Otherwise, the combinational outputs are instr_ready_out=0, instr_fault_out=0 and instr_read_value_out=NOP_WORD.
REQ-023 FSM states: IDLE, REQ, WAIT, DRAIN.
REQ-024 IDLE, on an aligned miss with flush_in=0: go to REQ; register mem_addr_out={instr_address_in[31:2],2'b00}; register mem_req_out=1.
REQ-025 REQ: mem_req_out and mem_addr_out are held stable until mem_gnt_in=1, even if instr_address_in changes.
- On the grant cycle: go to WAIT, mem_req_out=0, timeout counter cleared.
- flush_in in REQ without a grant: go to IDLE, mem_req_out=0.
- flush_in in REQ with a grant: go to DRAIN.
REQ-026 WAIT, on mem_rvalid_in with flush_in=0: load hold_valid=1, hold_tag=mem_addr_out[31:2], hold_fault=mem_err_in; go to IDLE.
- hold_data=mem_err_in ? NOP_WORD : mem_rdata_in.
- instr_ready_out can rise no earlier than the cycle after mem_rvalid_in.
REQ-027 WAIT, without mem_rvalid_in: the counter increments each enabled cycle.
- When the counter reaches TIMEOUT_CYCLES, load hold_valid=1, hold_tag=mem_addr_out[31:2], hold_data=NOP_WORD, hold_fault=1; go to DRAIN.
REQ-028 WAIT with flush_in=1 and mem_rvalid_in=0: go to DRAIN, counter cleared.
REQ-029 WAIT with flush_in=1 and mem_rvalid_in=1 in the same cycle: the response is discarded, hold_valid=0, go to IDLE.
REQ-030 DRAIN: mem_rvalid_in is discarded and the FSM goes to IDLE; if no response arrives within TIMEOUT_CYCLES, go to IDLE regardless. No new request is issued from DRAIN.
REQ-031 flush_in in any state clears hold_valid at the next edge. A same-cycle fill is overridden by the flush.
REQ-032 A response whose tag no longer matches instr_address_in still fills the holding register; the mismatch is then handled as a miss from IDLE.
REQ-033 Miss latency: with the miss in cycle 0, mem_req_out=1 in cycle 1.
- Grant in cycle 1 and rvalid in cycle 2 give instr_ready_out=1 in cycle 3 (minimum latency, 3 cycles).
REQ-034 instr_read_in=0 never starts a request. An active transaction completes normally.

Reset
REQ-035 While reset is asserted, asynchronously:
- state=IDLE, mem_req_out=0, mem_addr_out=0;
- hold_valid=0, hold_tag=0, hold_data=NOP_WORD, hold_fault=0, counter=0.
REQ-036 After reset, the outputs are instr_ready_out=0, instr_fault_out=0 and instr_read_value_out=NOP_WORD until the first fill or misaligned request.
REQ-037 Reset asserted mid-transaction abandons it. A later stray mem_rvalid_in in IDLE is ignored.

Verification
REQ-038 Miss-then-hit: read 0x100; gnt in cycle 1, rvalid in cycle 2 with data 0xDEADBEEF.
- Response: ready=1 with 0xDEADBEEF in cycle 3.
- A repeat read of 0x100 gets ready=1 in the same cycle with no bus request.
REQ-039 Misaligned: read 0x102 -> same cycle ready=1, fault=1, value=0x00000013, mem_req_out stays 0.
REQ-040 Bus error: rvalid with mem_err_in=1 -> next cycle ready=1, fault=1, value=0x00000013.
REQ-041 Timeout: TIMEOUT_CYCLES=4, no rvalid -> faulted word held after 4 WAIT cycles.
- A late rvalid is dropped in DRAIN and the FSM returns to IDLE.
REQ-042 Flush: flush_in in WAIT with the response 2 cycles later -> the response is discarded and hold_valid=0.
- A subsequent read of the same address issues a new request.
- Also cover flush_in coinciding with rvalid: no fill.
REQ-043 Reset mid-WAIT -> all outputs at reset values immediately; a following stray rvalid causes no fill.
